// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the lockstep recovery controller
package ft_pkg;
  typedef enum logic [1:0] {IDLE, RESTORE, FLUSH, PCLOAD} ft_rec_state_e;
  localparam int ERR_CNT_W = 8;
  localparam logic [31:0] DEF_BOOT_PC = 32'h80;
endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// ft_rec_if: core write ports, golden RF and fetch-side signals of the recovery controller
interface ft_rec_if import ft_pkg::*; #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  we_a_i, we_b_i;
  logic [ADDR_WIDTH-1:0] addr_a_i, addr_b_i;
  logic [DATA_WIDTH-1:0] data_a_i, data_b_i;
  logic [DATA_WIDTH-1:0] spc_i;
  logic                  commit_we_o;
  logic [ADDR_WIDTH-1:0] commit_addr_o;
  logic [DATA_WIDTH-1:0] commit_data_o;
  logic [ADDR_WIDTH-1:0] gold_raddr_o;
  logic [DATA_WIDTH-1:0] gold_rdata_i;
  logic                  rst_we_o;
  logic [ADDR_WIDTH-1:0] rst_addr_o;
  logic [DATA_WIDTH-1:0] rst_data_o;
  logic                  fetch_block_o;
  logic [DATA_WIDTH-1:0] spc_o;
  logic                  pc_load_o;
  logic [ERR_CNT_W-1:0]  err_count_o;
  modport master (
    output we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i, spc_i, gold_rdata_i,
    input  commit_we_o, commit_addr_o, commit_data_o, gold_raddr_o, rst_we_o, rst_addr_o,
           rst_data_o, fetch_block_o, spc_o, pc_load_o, err_count_o
  );
  modport slave (
    input  we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i, spc_i, gold_rdata_i,
    output commit_we_o, commit_addr_o, commit_data_o, gold_raddr_o, rst_we_o, rst_addr_o,
           rst_data_o, fetch_block_o, spc_o, pc_load_o, err_count_o
  );
endinterface

// File: rtl/ft_write_cmp.sv
// ft_write_cmp: combinational lockstep comparison of the two cores' RF write ports
module ft_write_cmp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  mismatch,
  output logic                  match
);
  logic same;
  assign same     = (addr_a == addr_b) && (data_a == data_b);
  assign mismatch = (we_a != we_b) || (we_a && we_b && !same);
  assign match    = we_a && we_b && same;
endmodule

// File: rtl/ft_recovery_ctrl.sv
// ft_recovery_ctrl: commits matching lockstep writes, replays the golden RF and reloads the checkpoint PC on mismatch
module ft_recovery_ctrl import ft_pkg::*; #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_PC    = DEF_BOOT_PC
) (
  input logic    clk_i,
  input logic    rst_ni,
  ft_rec_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  ft_rec_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  commit_we_q, commit_we_d;
  logic [ADDR_WIDTH-1:0] commit_addr_q, commit_addr_d;
  logic [DATA_WIDTH-1:0] commit_data_q, commit_data_d;
  logic [DATA_WIDTH-1:0] spc_q, spc_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic                  mismatch, match, rst_we;
  ft_write_cmp #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .we_a(bus.we_a_i), .we_b(bus.we_b_i),
    .addr_a(bus.addr_a_i), .addr_b(bus.addr_b_i),
    .data_a(bus.data_a_i), .data_b(bus.data_b_i),
    .mismatch(mismatch), .match(match)
  );
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    commit_we_d   = 1'b0;
    commit_addr_d = commit_addr_q;
    commit_data_d = commit_data_q;
    spc_d         = spc_q;
    err_d         = err_q;
    case (state_q)
      IDLE: begin
        if (mismatch) begin
          state_d = RESTORE;
          cnt_d   = '0;
          err_d   = (&err_q) ? err_q : err_q + ERR_CNT_W'(1);
        end else if (match) begin
          commit_we_d   = 1'b1;
          commit_addr_d = bus.addr_a_i;
          commit_data_d = bus.data_a_i;
          spc_d         = bus.spc_i;
        end
      end
      RESTORE: begin
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        state_d = (cnt_q == LAST) ? FLUSH : RESTORE;
      end
      FLUSH:   state_d = PCLOAD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      commit_we_q   <= 1'b0;
      commit_addr_q <= '0;
      commit_data_q <= '0;
      spc_q         <= BOOT_PC;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      commit_we_q   <= commit_we_d;
      commit_addr_q <= commit_addr_d;
      commit_data_q <= commit_data_d;
      spc_q         <= spc_d;
      err_q         <= err_d;
    end
  end
  // golden read data lags the address by one cycle, so the replay trails cnt by one
  assign rst_we            = (state_q == RESTORE && cnt_q != '0) || state_q == FLUSH;
  assign bus.rst_we_o      = rst_we;
  assign bus.rst_addr_o    = rst_we ? cnt_q - ADDR_WIDTH'(1) : '0;
  assign bus.rst_data_o    = rst_we ? bus.gold_rdata_i : '0;
  assign bus.gold_raddr_o  = (state_q == RESTORE) ? cnt_q : '0;
  assign bus.fetch_block_o = state_q != IDLE;
  assign bus.pc_load_o     = state_q == PCLOAD;
  assign bus.commit_we_o   = commit_we_q;
  assign bus.commit_addr_o = commit_addr_q;
  assign bus.commit_data_o = commit_data_q;
  assign bus.spc_o         = spc_q;
  assign bus.err_count_o   = err_q;
endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// tb_ft_recovery_ctrl: randomized lockstep/recovery stimulus checked against a recovery-timeline reference model
module tb_ft_recovery_ctrl;
  import ft_pkg::*;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 1 << AW;
  localparam logic [DW-1:0] BOOT = 32'h80;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ft_rec_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ft_recovery_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_PC(BOOT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );
  logic [DW-1:0] env_rf [N];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.commit_we_o) env_rf[bus.commit_addr_o] <= bus.commit_data_o;
    rdata_q <= env_rf[bus.gold_raddr_o];
  end
  assign bus.gold_rdata_i = rdata_q;
  int total = 0;
  int bad = 0;
  // k = cycles since the mismatch was sampled (0 = running normally)
  int            k;
  logic          m_cwe;
  logic [AW-1:0] m_caddr;
  logic [DW-1:0] m_cdata, m_spc;
  int            m_err;
  logic [DW-1:0] gold [N];
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    k = 0; m_cwe = 1'b0; m_caddr = '0; m_cdata = '0; m_spc = BOOT; m_err = 0;
  endtask
  task automatic check_outputs();
    logic rw;
    rw = (k >= 2) && (k <= N + 1);
    chk("fetch_block", DW'(bus.fetch_block_o), DW'(k != 0));
    chk("pc_load", DW'(bus.pc_load_o), DW'(k == N + 2));
    chk("rst_we", DW'(bus.rst_we_o), DW'(rw));
    chk("rst_addr", DW'(bus.rst_addr_o), rw ? DW'(k - 2) : '0);
    chk("rst_data", bus.rst_data_o, rw ? gold[k-2] : '0);
    if (k >= 1 && k <= N) chk("gold_raddr", DW'(bus.gold_raddr_o), DW'(k - 1));
    chk("commit_we", DW'(bus.commit_we_o), DW'(m_cwe));
    chk("commit_addr", DW'(bus.commit_addr_o), DW'(m_caddr));
    chk("commit_data", bus.commit_data_o, m_cdata);
    chk("spc", bus.spc_o, m_spc);
    chk("err_count", DW'(bus.err_count_o), DW'(m_err));
  endtask
  task automatic step(input logic wa, input logic wb, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                      input logic [DW-1:0] da, input logic [DW-1:0] db, input logic [DW-1:0] sp);
    @(negedge clk);
    check_outputs();
    bus.we_a_i = wa; bus.we_b_i = wb; bus.addr_a_i = aa; bus.addr_b_i = ab;
    bus.data_a_i = da; bus.data_b_i = db; bus.spc_i = sp;
    if (k != 0) begin
      m_cwe = 1'b0;
      k = (k == N + 2) ? 0 : k + 1;
    end else if (wa != wb || (wa && (aa != ab || da != db))) begin
      m_cwe = 1'b0;
      k = 1;
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end else if (wa) begin
      m_cwe = 1'b1; m_caddr = aa; m_cdata = da; m_spc = sp; gold[aa] = da;
    end else m_cwe = 1'b0;
  endtask
  task automatic idle_step();
    step(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask
  task automatic match_step();
    logic [AW-1:0] a;
    logic [DW-1:0] d, sp;
    a = AW'($urandom); d = $urandom; sp = $urandom;
    step(1'b1, 1'b1, a, a, d, d, sp);
  endtask
  task automatic mism_step();
    logic [AW-1:0] a;
    logic [DW-1:0] d, sp;
    a = AW'($urandom); d = $urandom; sp = $urandom;
    case ($urandom_range(3))
      0: step(1'b1, 1'b0, a, a, d, d, sp);
      1: step(1'b0, 1'b1, a, a, d, d, sp);
      2: step(1'b1, 1'b1, a, a ^ AW'($urandom_range(1, N - 1)), d, d, sp);
      default: step(1'b1, 1'b1, a, a, d, d ^ DW'($urandom_range(1, 255)), sp);
    endcase
  endtask
  task automatic ride_out(input logic junk);
    for (int i = 0; i < N + 3 && k != 0; i++) if (junk) mism_step(); else idle_step();
  endtask
  initial begin
    #3_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < N; i++) begin env_rf[i] = '0; gold[i] = '0; end
    bus.we_a_i = 1'b0; bus.we_b_i = 1'b0; bus.addr_a_i = '0; bus.addr_b_i = '0;
    bus.data_a_i = '0; bus.data_b_i = '0; bus.spc_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, AW'(i), AW'(i), DW'(i * 10), DW'(i * 10), BOOT);
    repeat (2) idle_step();
    step(1'b1, 1'b0, AW'(10), AW'(10), DW'(100), DW'(100), 32'h1234);
    ride_out(1'b0);
    idle_step();
    chk("fill_reg10", env_rf[10], DW'(100));
    step(1'b1, 1'b1, AW'(7), AW'(7), DW'(70), DW'(71), 32'h2222);
    ride_out(1'b1);
    idle_step();
    chk("reg7_kept", env_rf[7], DW'(70));
    repeat (5) match_step();
    mism_step();
    for (int i = 0; i < N && k != 13; i++) idle_step();
    chk("reached_cnt12", DW'(k), DW'(13));
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus.we_a_i = 1'b0; bus.we_b_i = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) idle_step();
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(9);
      if (k != 0) begin
        if (r < 5) mism_step(); else idle_step();
      end else if (r == 0) mism_step();
      else if (r <= 5) match_step();
      else idle_step();
    end
    ride_out(1'b0);
    for (int i = 0; i < 260; i++) begin
      mism_step();
      ride_out(1'b1);
    end
    idle_step();
    chk("err_saturated", DW'(bus.err_count_o), DW'(255));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ft_recovery_ctrl.md
# ft_recovery_ctrl

Duplex-lockstep write checker and rollback sequencer for the fault-tolerant system. It compares the register-file write ports of the two redundant cores every cycle and forwards matching writes to the golden register file. On a mismatch it blocks fetch, replays every golden register back into both cores, and restores the checkpointed PC. It sits between the two cores' write-back stages and the golden register file / fetch unit.

## Interface
- ADDR_WIDTH, 5, register address width; N = 2**ADDR_WIDTH registers
- DATA_WIDTH, 32, register/PC data width
- BOOT_PC, 32'h80, checkpoint PC value after reset
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- we_a_i, we_b_i  in  1  write enables, core A / core B
- addr_a_i, addr_b_i  in  ADDR_WIDTH  write addresses
- data_a_i, data_b_i  in  DATA_WIDTH  write data
- spc_i  in  DATA_WIDTH  PC of the instruction presenting the write
- commit_we_o  out  1  golden RF write enable
- commit_addr_o  out  ADDR_WIDTH  golden RF write address
- commit_data_o  out  DATA_WIDTH  golden RF write data
- gold_raddr_o  out  ADDR_WIDTH  golden RF read address; read data returns next cycle
- gold_rdata_i  in  DATA_WIDTH  golden RF read data
- rst_we_o  out  1  restore write enable, to both cores' RFs
- rst_addr_o  out  ADDR_WIDTH  restore address
- rst_data_o  out  DATA_WIDTH  restore data
- fetch_block_o  out  1  stall both cores' fetch
- spc_o  out  DATA_WIDTH  checkpoint PC
- pc_load_o  out  1  one-cycle pulse: cores load spc_o
- err_count_o  out  8  saturating mismatch counter

## Operation
- Compare (IDLE only): mismatch = (we_a_i != we_b_i), or (we_a_i & we_b_i & (addr or data differ)). Both enables low = no write, no error.
- Match with both enables high: register commit_we_o=1, commit_addr_o/commit_data_o = port A values; latch spc_i into checkpoint (spc_o).
- Mismatch: no commit, checkpoint unchanged, err_count_o += 1 (saturates at 255), go to RESTORE, counter cnt=0.
- States:
  - IDLE: fetch_block_o=0.
  - RESTORE: gold_raddr_o=cnt; cnt increments each cycle; from the second RESTORE cycle, rst_we_o=1 with rst_addr_o=cnt-1 and rst_data_o=gold_rdata_i. After cnt=N-1 is issued, go to FLUSH.
  - FLUSH: write of register N-1; go to PCLOAD.
  - PCLOAD: pc_load_o=1; go to IDLE.
- fetch_block_o=1 in RESTORE, FLUSH and PCLOAD. All core write inputs are ignored (no compare, no commit, no count) outside IDLE.
- cnt is ADDR_WIDTH wide and wraps naturally. The FSM exit is decoded at cnt == N-1, not on overflow.

## Timing
- Reset values: state IDLE, cnt 0, commit_we_o 0, commit addr/data 0, rst_we_o 0, rst addr/data 0, gold_raddr_o 0, fetch_block_o 0, pc_load_o 0, spc_o BOOT_PC, err_count_o 0.
- Commit latency: 1 cycle, from matching inputs to commit_* outputs.
- fetch_block_o rises the cycle after the mismatch is sampled. It stays high for exactly N+2 cycles (N RESTORE, 1 FLUSH, 1 PCLOAD).
- rst_we_o is high for exactly N consecutive cycles, addresses 0..N-1 in order, starting one cycle after RESTORE entry.
- Commit and restore never overlap. The last commit, if any, precedes the mismatch cycle.
- Reset asserted mid-recovery aborts immediately to reset values; no partial replay resumes.
- A mismatch in the cycle PCLOAD returns to IDLE is not sampled; sampling resumes the following cycle.

## Structure
- Package ft_pkg holds:
  - enum ft_rec_state_e {IDLE, RESTORE, FLUSH, PCLOAD}
  - ERR_CNT_W = 8
  - default BOOT_PC
- Sub-module ft_write_cmp: purely combinational mismatch/match detector over the two write ports. The FSM, counter and registers live in ft_recovery_ctrl.

## Test plan
- Lockstep fill: write reg i = i*10 on both ports for i=0..31, with spc_i=32'h80. Required: 32 commits, each 1 cycle late; fetch_block_o stays 0; err_count_o=0; spc_o=32'h80.
- Enable mismatch: we_a=1, we_b=0, addr 10, data 100. Required:
  - no commit to reg 10
  - fetch_block_o high for 34 cycles
  - rst writes reg i = i*10 (golden values) for i=0..31
  - pc_load_o pulses once with spc_o = last committed PC
  - err_count_o=1
- Data mismatch: addr 7 on both ports, data 70 vs 71. Same recovery sequence as the enable mismatch; reg 7 is restored to its prior golden value.
- Ignored-during-recovery: drive random mismatching writes throughout RESTORE. Required: err_count_o increments only once; no commit_we_o pulses.
- Reset mid-recovery: drop rst_ni at RESTORE cnt=12. Required: all outputs take reset values asynchronously; spc_o=32'h80; after release, IDLE with no further rst_we_o.
- Saturation: force 260 separate mismatches. Required: err_count_o holds at 255.
